time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The module SHALL have parameter DEB_CYC, default 1_000_000, meaning consecutive stable clk cycles required to accept a button level change.
REQ-002 The module SHALL have parameter BLINK_CYC, default 25_000_000, meaning clk cycles per blink half-period.
REQ-003 The module SHALL have port clk, input, 1 bit: system clock; all state on rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port btn_mode, input, 1 bit: raw, asynchronous, active-high mode button.
REQ-006 The module SHALL have port btn_inc, input, 1 bit: raw, asynchronous, active-high increment button.
REQ-007 The module SHALL have port cur_min, input, 6 bits: current minutes from the timekeeper.
REQ-008 The module SHALL have port cur_hour, input, 5 bits: current hours from the timekeeper.
REQ-009 The module SHALL have port run_en, output, 1 bit: timekeeper count enable.
REQ-010 The module SHALL have port ld, output, 1 bit: one-cycle load strobe to the timekeeper.
REQ-011 The module SHALL have port ld_min, output, 6 bits: edited minutes, held continuously.
REQ-012 The module SHALL have port ld_hour, output, 5 bits: edited hours, held continuously.
REQ-013 The module SHALL have port mode, output, 2 bits: 00 RUN, 01 SET_MIN, 10 SET_HR.
REQ-014 The module SHALL have port blank, output, 4 bits: per-digit blank mask; [3:2] hour digits, [1:0] minute digits.

Function
REQ-015 Each button SHALL pass through a 2-FF synchronizer before any other use.
REQ-016 Per button, a debounce counter SHALL clear whenever the synchronized level equals the stable level; the stable level SHALL update when they differ for DEB_CYC consecutive cycles.
REQ-017 A press pulse SHALL be generated for exactly one cycle on each 0->1 transition of the stable level; release SHALL generate no pulse.
REQ-018 RUN + mode press SHALL go to SET_MIN and, on that same edge, capture cur_min/cur_hour into the edit registers, replacing cur_min>59 or cur_hour>23 with 0.
REQ-019 SET_MIN + mode press SHALL go to SET_HR.
REQ-020 SET_HR + mode press SHALL go to RUN and assert ld for exactly that one cycle.
REQ-021 SET_MIN + inc press SHALL increment the edit minutes: 59 wraps to 0, with no carry into hours.
REQ-022 SET_HR + inc press SHALL increment the edit hours: 23 wraps to 0.
REQ-023 An inc press in RUN SHALL be ignored.
REQ-024 When mode and inc press in the same cycle, mode SHALL take effect and inc SHALL be discarded.
REQ-025 run_en SHALL be registered: 1 while mode is RUN (including the ld cycle), 0 in SET_MIN and SET_HR.
REQ-026 The blink phase SHALL toggle every BLINK_CYC cycles and SHALL reset to 0 (visible) on every state entry and every accepted inc press.
REQ-027 blank SHALL be 4'b0011 in SET_MIN with phase 1, 4'b1100 in SET_HR with phase 1, and 4'b0000 otherwise.
REQ-028 ld_min/ld_hour SHALL always reflect the edit registers and change only on capture or inc.

Reset
REQ-029 rst low SHALL asynchronously force: mode RUN, run_en 1, ld 0, ld_min 0, ld_hour 0, blank 0, blink phase 0, all debounce counters 0, synchronizer and stable levels 0.
REQ-030 Reset during SET_MIN or SET_HR SHALL discard the edits, with no ld pulse during or after reset.
REQ-031 Release of rst SHALL be followed by normal operation with the button stable levels at 0, so a button already held produces one press after DEB_CYC cycles.

Verification (DEB_CYC=4, BLINK_CYC=8 in the bench)
REQ-032 Glitch: btn_mode high for 3 cycles, then low -> no press, mode stays 00.
REQ-033 Full edit: cur_min=58, cur_hour=23; mode press; inc x2; mode; inc x1; mode -> ld high exactly 1 cycle with ld_min=0, ld_hour=0, mode 00, run_en 1.
REQ-034 Clamp: cur_min=63, cur_hour=30, mode press -> ld_min=0, ld_hour=0, mode 01, run_en 0.
REQ-035 Simultaneous: in SET_MIN with edit min 10, mode and inc pressed same cycle -> mode 10, ld_min stays 10.
REQ-036 Blink: in SET_MIN, blank=0000 for 8 cycles, then 0011 for 8 cycles; an inc press mid-phase-1 forces blank=0000 on the next cycle.
REQ-037 Reset mid-edit: SET_HR with edits pending, assert rst -> mode 00, ld never pulses, ld_min=ld_hour=0.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/inc buttons drive a RUN -> SET_MIN -> SET_HR edit loop,
// loading edited time back into the timekeeper with a one-cycle strobe and blinking the edited digits.
module time_set_ctrl #(
   parameter int unsigned DEB_CYC   = 1_000_000,
   parameter int unsigned BLINK_CYC = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] cur_min,
   input  logic [4:0] cur_hour,
   output logic       run_en,
   output logic       ld,
   output logic [5:0] ld_min,
   output logic [4:0] ld_hour,
   output logic [1:0] mode,
   output logic [3:0] blank
);

   localparam int unsigned DW = $clog2(DEB_CYC + 1);
   localparam int unsigned BW = $clog2(BLINK_CYC + 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

   typedef enum logic [1:0] {
      StRun    = 2'b00,
      StSetMin = 2'b01,
      StSetHr  = 2'b10
   } state_t;

   // Index 0 is the mode button, index 1 the increment button.
   logic [1:0]    btn_raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    stable;
   logic [1:0]    press;
   logic [DW-1:0] deb_cnt [2];

   assign btn_raw = {btn_inc, btn_mode};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         press  <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i] <= '0;
               stable[i]  <= sync2[i];
               // Only a rising stable level produces a press.
               press[i]   <= sync2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   logic press_mode;
   logic press_inc;

   assign press_mode = press[0];
   assign press_inc  = press[1];

   function automatic logic [3:0] blank_of(input state_t s, input logic ph);
      logic [3:0] b;
      b = 4'b0000;
      if (ph) begin
         case (s)
            StSetMin: b = 4'b0011;
            StSetHr:  b = 4'b1100;
            default:  b = 4'b0000;
         endcase
      end
      return b;
   endfunction

   state_t        state;
   logic [5:0]    edit_min;
   logic [4:0]    edit_hour;
   logic          phase;
   logic [BW-1:0] blink_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StRun;
         run_en    <= 1'b1;
         ld        <= 1'b0;
         edit_min  <= '0;
         edit_hour <= '0;
         phase     <= 1'b0;
         blink_cnt <= '0;
         blank     <= '0;
      end else begin
         ld <= 1'b0;
         if (press_mode) begin
            // Mode wins over a simultaneous inc; every state entry restarts the blink visible.
            phase     <= 1'b0;
            blink_cnt <= '0;
            blank     <= '0;
            case (state)
               StRun: begin
                  state     <= StSetMin;
                  run_en    <= 1'b0;
                  edit_min  <= (cur_min > 6'd59) ? 6'd0 : cur_min;
                  edit_hour <= (cur_hour > 5'd23) ? 5'd0 : cur_hour;
               end
               StSetMin: begin
                  state <= StSetHr;
               end
               default: begin
                  state  <= StRun;
                  run_en <= 1'b1;
                  ld     <= 1'b1;
               end
            endcase
         end else if (press_inc && (state != StRun)) begin
            phase     <= 1'b0;
            blink_cnt <= '0;
            blank     <= '0;
            if (state == StSetMin) begin
               edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
            end else begin
               edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
            end
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
            blank     <= blank_of(state, ~phase);
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
            blank     <= blank_of(state, phase);
         end
      end
   end

   assign mode    = state;
   assign ld_min  = edit_min;
   assign ld_hour = edit_hour;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed table of button actions, hand-written corner sequences,
// and a cycle-by-cycle behavioural model checked under random button/reset activity.
module tb_time_set_ctrl;

   localparam int unsigned DEB   = 4;
   localparam int unsigned BLINK = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] cur_min = '0;
   logic [4:0] cur_hour = '0;
   logic       run_en;
   logic       ld;
   logic [5:0] ld_min;
   logic [4:0] ld_hour;
   logic [1:0] mode;
   logic [3:0] blank;

   time_set_ctrl #(
      .DEB_CYC   (DEB),
      .BLINK_CYC (BLINK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .cur_min  (cur_min),
      .cur_hour (cur_hour),
      .run_en   (run_en),
      .ld       (ld),
      .ld_min   (ld_min),
      .ld_hour  (ld_hour),
      .mode     (mode),
      .blank    (blank)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int ld_cnt = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) if (ld) ld_cnt++;

   // Behavioural model: queues stand in for the two-stage synchronizer, a run length of
   // disagreeing samples gives the debounce, and blink phase is derived from age since restart.
   bit mq[$];
   bit iq[$];
   int m_stable[2];
   int m_run[2];
   bit pend[2];
   int m_state;
   int m_min;
   int m_hour;
   int m_age;
   bit m_ld;

   task automatic model_reset();
      mq.delete(); mq.push_back(1'b0); mq.push_back(1'b0);
      iq.delete(); iq.push_back(1'b0); iq.push_back(1'b0);
      for (int b = 0; b < 2; b++) begin
         m_stable[b] = 0; m_run[b] = 0; pend[b] = 1'b0;
      end
      m_state = 0; m_min = 0; m_hour = 0; m_age = 0; m_ld = 1'b0;
   endtask

   task automatic model_step();
      int seen[2];
      m_ld = 1'b0;
      if (pend[0]) begin
         m_age = 0;
         if (m_state == 0) begin
            m_state = 1;
            m_min   = (int'(cur_min) > 59) ? 0 : int'(cur_min);
            m_hour  = (int'(cur_hour) > 23) ? 0 : int'(cur_hour);
         end else if (m_state == 1) begin
            m_state = 2;
         end else begin
            m_state = 0;
            m_ld    = 1'b1;
         end
      end else if (pend[1] && m_state != 0) begin
         m_age = 0;
         if (m_state == 1) m_min = (m_min + 1) % 60;
         else m_hour = (m_hour + 1) % 24;
      end else begin
         m_age++;
      end
      seen[0] = int'(mq.pop_front()); mq.push_back(btn_mode);
      seen[1] = int'(iq.pop_front()); iq.push_back(btn_inc);
      for (int b = 0; b < 2; b++) begin
         pend[b] = 1'b0;
         if (seen[b] == m_stable[b]) begin
            m_run[b] = 0;
         end else begin
            m_run[b]++;
            if (m_run[b] == int'(DEB)) begin
               m_stable[b] = seen[b];
               m_run[b]    = 0;
               pend[b]     = (seen[b] == 1);
            end
         end
      end
   endtask

   always @(posedge clk) begin
      int exp_v;
      int act_v;
      int bl;
      if (!rst) model_reset();
      else model_step();
      #1;
      if (chk_en) begin
         bl = 0;
         if (((m_age / int'(BLINK)) % 2) == 1) bl = (m_state == 1) ? 3 : (m_state == 2) ? 12 : 0;
         exp_v = (m_state << 17) | ((m_state == 0 ? 1 : 0) << 16) | (int'(m_ld) << 15) |
                 (m_min << 9) | (m_hour << 4) | bl;
         act_v = int'({mode, run_en, ld, ld_min, ld_hour, blank});
         check("model", act_v, exp_v);
      end
   end

   task automatic press(input int op);
      btn_mode = op[0];
      btn_inc  = op[1];
      repeat (6) @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // op: 1 mode, 2 inc, 3 both in the same cycle
   typedef struct {
      int op; int cmin; int chour;
      int e_mode; int e_min; int e_hour; int e_run; int e_ld;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int l0;
      int k;
      bit found;
      tbl = '{
         '{2, 58, 23, 0,  0,  0, 1, 0},
         '{1, 63, 30, 1,  0,  0, 0, 0},
         '{1,  0,  0, 2,  0,  0, 0, 0},
         '{1,  0,  0, 0,  0,  0, 1, 1},
         '{1, 58, 23, 1, 58, 23, 0, 0},
         '{2,  0,  0, 1, 59, 23, 0, 0},
         '{2,  0,  0, 1,  0, 23, 0, 0},
         '{1,  0,  0, 2,  0, 23, 0, 0},
         '{2,  0,  0, 2,  0,  0, 0, 0},
         '{1,  0,  0, 0,  0,  0, 1, 1},
         '{1,  9,  5, 1,  9,  5, 0, 0},
         '{2,  0,  0, 1, 10,  5, 0, 0},
         '{3,  0,  0, 2, 10,  5, 0, 0},
         '{2,  0,  0, 2, 10,  6, 0, 0},
         '{3,  0,  0, 0, 10,  6, 1, 1}
      };

      repeat (3) @(negedge clk);
      check("reset_mode", int'(mode), 0);
      check("reset_run_en", int'(run_en), 1);
      check("reset_ld", int'(ld), 0);
      check("reset_ld_min", int'(ld_min), 0);
      check("reset_ld_hour", int'(ld_hour), 0);
      check("reset_blank", int'(blank), 0);
      rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // Three-cycle glitch must not register
      btn_mode = 1'b1;
      repeat (3) @(negedge clk);
      btn_mode = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_mode", int'(mode), 0);

      for (int i = 0; i < 15; i++) begin
         cur_min  = 6'(tbl[i].cmin);
         cur_hour = 5'(tbl[i].chour);
         l0 = ld_cnt;
         press(tbl[i].op);
         check($sformatf("row%0d_mode", i), int'(mode), tbl[i].e_mode);
         check($sformatf("row%0d_ld_min", i), int'(ld_min), tbl[i].e_min);
         check($sformatf("row%0d_ld_hour", i), int'(ld_hour), tbl[i].e_hour);
         check($sformatf("row%0d_run_en", i), int'(run_en), tbl[i].e_run);
         check($sformatf("row%0d_ld_cycles", i), ld_cnt - l0, tbl[i].e_ld);
      end

      // Blink: entry into SET_MIN, 8 visible cycles then 8 blanked
      cur_min  = 6'd20;
      cur_hour = 5'd3;
      btn_mode = 1'b1;
      repeat (6) @(negedge clk);
      btn_mode = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("blink_vis%0d", i), int'(blank), 0);
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         check($sformatf("blink_blank%0d", i), int'(blank), 3);
         @(negedge clk);
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (blank == 4'b0011) found = 1'b1;
         else @(negedge clk);
      end
      check("blink_resume", int'(found), 1);
      btn_inc = 1'b1;
      repeat (6) @(negedge clk);
      check("blink_pre_inc", int'(blank), 3);
      btn_inc = 1'b0;
      @(negedge clk);
      check("blink_inc_restart", int'(blank), 0);
      check("blink_inc_min", int'(ld_min), 21);
      repeat (8) @(negedge clk);

      // Reset in SET_HR with pending edits
      press(1);
      press(2);
      check("pre_reset_mode", int'(mode), 2);
      check("pre_reset_hour", int'(ld_hour), 4);
      l0 = ld_cnt;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("in_reset_mode", int'(mode), 0);
      check("in_reset_run_en", int'(run_en), 1);
      check("in_reset_ld_min", int'(ld_min), 0);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("post_reset_mode", int'(mode), 0);
      check("post_reset_ld_hour", int'(ld_hour), 0);
      check("post_reset_no_ld", ld_cnt - l0, 0);

      // Button held through reset gives exactly one press afterwards
      btn_mode = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      k = 0;
      while (mode != 2'b01 && k < 15) begin
         @(negedge clk);
         k++;
      end
      check("held_press_mode", int'(mode), 1);
      check("held_press_not_early", int'(k >= int'(DEB)), 1);
      repeat (10) @(negedge clk);
      check("held_single_press", int'(mode), 1);
      btn_mode = 1'b0;
      repeat (8) @(negedge clk);
      press(1);
      press(1);
      check("held_back_to_run", int'(mode), 0);

      // Random activity against the model
      for (int i = 0; i < 400; i++) begin
         btn_mode = ($urandom_range(0, 3) == 0);
         btn_inc  = ($urandom_range(0, 2) == 0);
         cur_min  = 6'($urandom_range(0, 63));
         cur_hour = 5'($urandom_range(0, 31));
         rst      = ($urandom_range(0, 40) != 0);
         repeat ($urandom_range(1, 10)) @(negedge clk);
      end
      rst = 1'b1;
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      repeat (20) @(negedge clk);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
